// File: rtl/light_sched_pkg.sv
// Shared types and constants for the light scheduler: FSM states,
// phase codes driven on the phase output, and default field widths.
package light_sched_pkg;

  localparam int TW_DEF = 6;  // phase-length / remaining width (scp_079 timer width)
  localparam int RW_DEF = 4;  // round-count width

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    RED    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;
  localparam logic [1:0] PH_RED    = 2'd3;

endpackage

// File: rtl/light_scheduler_if.sv
// Request/status bundle between a controller (master) and the light
// scheduler (slave). Clock and reset stay plain module ports.
interface light_scheduler_if
  import light_sched_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int RW = RW_DEF
) ();

  logic          start;
  logic [TW-1:0] green_len;
  logic [TW-1:0] yellow_len;
  logic [TW-1:0] red_len;
  logic [RW-1:0] rounds;
  logic          hold;
  logic          abort;

  logic          green;
  logic          yellow;
  logic          red;
  logic [1:0]    phase;
  logic [TW-1:0] remaining;
  logic          busy;
  logic          done;
  logic          aborted;

  modport master (
    output start, green_len, yellow_len, red_len, rounds, hold, abort,
    input  green, yellow, red, phase, remaining, busy, done, aborted
  );

  modport slave (
    input  start, green_len, yellow_len, red_len, rounds, hold, abort,
    output green, yellow, red, phase, remaining, busy, done, aborted
  );

endinterface

// File: rtl/phase_timer.sv
// Down-counter timing a single phase. load has priority over hold;
// a loaded value of 0 parks the counter at zero (idle value of remaining).
module phase_timer #(
  parameter int TW = 6
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic [TW-1:0] value,
  input  logic          hold,
  output logic [TW-1:0] count,
  output logic          last
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: reload, freeze, or decrement toward zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (!hold && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == TW'(1));

endmodule

// File: rtl/light_scheduler.sv
// Programmable green/yellow/red phase sequencer for scp_079. Lengths and a
// round count are latched on start; zero-length phases are skipped; hold
// freezes a run, abort kills it. Every output comes straight from a flop.
module light_scheduler
  import light_sched_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int RW = RW_DEF
) (
  input logic               clock,
  input logic               reset_n,
  light_scheduler_if.slave  bus
);

  state_t        state_q, state_d;
  logic [TW-1:0] green_len_q, green_len_d;
  logic [TW-1:0] yellow_len_q, yellow_len_d;
  logic [TW-1:0] red_len_q, red_len_d;
  logic [RW-1:0] rounds_q, rounds_d;

  logic          green_q, green_d;
  logic          yellow_q, yellow_d;
  logic          red_q, red_d;
  logic [1:0]    phase_q, phase_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_hold;
  logic [TW-1:0] timer_count;
  logic          timer_last;

  state_t        first_in;    // first nonzero phase of the incoming request
  state_t        first_q;     // first nonzero phase of the latched schedule
  state_t        after_q;     // next nonzero phase in this round, DONE if none
  logic          in_busy;

  // First nonzero phase strictly after cur (IDLE counts as "before green").
  function automatic state_t next_phase(input state_t cur, input logic [TW-1:0] g,
                                        input logic [TW-1:0] y, input logic [TW-1:0] r);
    state_t nxt;
    nxt = DONE;
    if (cur == IDLE && g != '0) begin
      nxt = GREEN;
    end else if ((cur == IDLE || cur == GREEN) && y != '0) begin
      nxt = YELLOW;
    end else if (cur != RED && r != '0) begin
      nxt = RED;
    end
    return nxt;
  endfunction

  // Length of the given phase; non-phase states map to 0 so the timer parks.
  function automatic logic [TW-1:0] phase_len(input state_t st, input logic [TW-1:0] g,
                                              input logic [TW-1:0] y, input logic [TW-1:0] r);
    logic [TW-1:0] len;
    case (st)
      GREEN:   len = g;
      YELLOW:  len = y;
      RED:     len = r;
      default: len = '0;
    endcase
    return len;
  endfunction

  assign first_in = next_phase(IDLE, bus.green_len, bus.yellow_len, bus.red_len);
  assign first_q  = next_phase(IDLE, green_len_q, yellow_len_q, red_len_q);
  assign after_q  = next_phase(state_q, green_len_q, yellow_len_q, red_len_q);
  assign in_busy  = (state_q == GREEN) || (state_q == YELLOW) || (state_q == RED);

  phase_timer #(.TW(TW)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .value   (timer_value),
    .hold    (timer_hold),
    .count   (timer_count),
    .last    (timer_last)
  );

  // State, latched schedule and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      green_len_q  <= '0;
      yellow_len_q <= '0;
      red_len_q    <= '0;
      rounds_q     <= '0;
      green_q      <= 1'b1;
      yellow_q     <= 1'b0;
      red_q        <= 1'b0;
      phase_q      <= PH_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      green_len_q  <= green_len_d;
      yellow_len_q <= yellow_len_d;
      red_len_q    <= red_len_d;
      rounds_q     <= rounds_d;
      green_q      <= green_d;
      yellow_q     <= yellow_d;
      red_q        <= red_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  // Next state: start acceptance, phase sequencing with skip, rounds, hold/abort.
  always_comb begin
    state_d      = state_q;
    green_len_d  = green_len_q;
    yellow_len_d = yellow_len_q;
    red_len_d    = red_len_q;
    rounds_d     = rounds_q;
    timer_load   = 1'b0;
    timer_value  = '0;
    timer_hold   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          green_len_d  = bus.green_len;
          yellow_len_d = bus.yellow_len;
          red_len_d    = bus.red_len;
          rounds_d     = bus.rounds;
          state_d      = (bus.rounds == '0) ? DONE : first_in;
          timer_load   = 1'b1;
          timer_value  = (bus.rounds == '0) ? '0 :
                         phase_len(first_in, bus.green_len, bus.yellow_len, bus.red_len);
        end
      end
      GREEN, YELLOW, RED: begin
        if (bus.abort) begin
          state_d    = IDLE;
          timer_load = 1'b1;
        end else if (bus.hold) begin
          timer_hold = 1'b1;
        end else if (timer_last) begin
          timer_load = 1'b1;
          if (after_q != DONE) begin
            state_d     = after_q;
            timer_value = phase_len(after_q, green_len_q, yellow_len_q, red_len_q);
          end else if (rounds_q != RW'(1)) begin
            rounds_d    = rounds_q - 1'b1;
            state_d     = first_q;
            timer_value = phase_len(first_q, green_len_q, yellow_len_q, red_len_q);
          end else begin
            rounds_d = '0;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    green_d   = 1'b1;
    yellow_d  = 1'b0;
    red_d     = 1'b0;
    phase_d   = PH_IDLE;
    busy_d    = 1'b0;
    done_d    = (state_d == DONE);
    aborted_d = in_busy && bus.abort;
    case (state_d)
      GREEN: begin
        phase_d = PH_GREEN;
        busy_d  = 1'b1;
      end
      YELLOW: begin
        green_d  = 1'b0;
        yellow_d = 1'b1;
        phase_d  = PH_YELLOW;
        busy_d   = 1'b1;
      end
      RED: begin
        green_d = 1'b0;
        red_d   = 1'b1;
        phase_d = PH_RED;
        busy_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.green     = green_q;
  assign bus.yellow    = yellow_q;
  assign bus.red       = red_q;
  assign bus.phase     = phase_q;
  assign bus.remaining = timer_count;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_light_scheduler.sv
// Bench for light_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a schedule-list model (each accepted run is
// expanded into a queue of {phase, remaining} slots, one per busy cycle).
module tb_light_scheduler;

  localparam int TW = 6;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  light_scheduler_if #(.TW(TW), .RW(RW)) bus ();

  light_scheduler #(.TW(TW), .RW(RW)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [1:0]    ph;
    logic [TW-1:0] rem;
  } slot_t;

  slot_t sched[$];
  int    m_mode = 0;          // 0 idle, 1 busy, 2 done cycle
  logic  m_aborted = 1'b0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    run_id = 0;
  int    obs_busy, obs_done, obs_abt, obs_yel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic clr_mon();
    obs_busy = 0; obs_done = 0; obs_abt = 0; obs_yel = 0;
  endtask

  task automatic check_outputs();
    logic [1:0]    eph;
    logic [TW-1:0] erem;
    logic          ebusy;
    eph = 2'd0; erem = '0; ebusy = 1'b0;
    if (m_mode == 1) begin
      eph = sched[0].ph; erem = sched[0].rem; ebusy = 1'b1;
    end
    chk("lights", {bus.green, bus.yellow, bus.red}, {(eph == 2'd0 || eph == 2'd1), eph == 2'd2, eph == 2'd3});
    chk("phase", bus.phase, eph);
    chk("remaining", bus.remaining, erem);
    chk("flags", {bus.busy, bus.done, bus.aborted}, {ebusy, m_mode == 2, m_aborted});
    if (bus.busy) obs_busy++;
    if (bus.done) obs_done++;
    if (bus.aborted) obs_abt++;
    if (bus.yellow) obs_yel++;
  endtask

  // One cycle: check current outputs, drive inputs for the next edge, advance model.
  task automatic step(input logic st, input int g, input int y, input int r,
                      input int n, input logic h, input logic ab);
    @(negedge clk);
    check_outputs();
    bus.start      = st;
    bus.green_len  = TW'(g);
    bus.yellow_len = TW'(y);
    bus.red_len    = TW'(r);
    bus.rounds     = RW'(n);
    bus.hold       = h;
    bus.abort      = ab;
    m_aborted = 1'b0;
    if (!rst_n) begin
      m_mode = 0;
      sched.delete();
    end else begin
      case (m_mode)
        0: if (st) begin
          for (int k = 0; k < n; k++)
            for (int p = 1; p <= 3; p++) begin
              int len;
              len = (p == 1) ? g : (p == 2) ? y : r;
              for (int i = len; i >= 1; i--) sched.push_back('{ph: 2'(p), rem: TW'(i)});
            end
          run_id++;
          m_mode = (sched.size() != 0) ? 1 : 2;
        end
        1: if (ab) begin
          sched.delete();
          m_mode = 0;
          m_aborted = 1'b1;
          $display("run %0d aborted at %0t", run_id, $time);
        end else if (!h) begin
          void'(sched.pop_front());
          if (sched.size() == 0) m_mode = 2;
        end
        default: begin
          m_mode = 0;
          $display("run %0d done at %0t", run_id, $time);
        end
      endcase
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic run_start(input int g, input int y, input int r, input int n);
    step(1'b1, g, y, r, n, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.green_len = '0; bus.yellow_len = '0; bus.red_len = '0;
    bus.rounds = '0; bus.hold = 1'b0; bus.abort = 1'b0;
    clr_mon();

    // Reset state, then release.
    idle_steps(3);
    rst_n = 1'b1;
    idle_steps(2);

    // Basic run 3/2/4 x1: 9 busy cycles, one done.
    clr_mon();
    run_start(3, 2, 4, 1);
    idle_steps(12);
    chk("basic_busy", obs_busy, 9);
    chk("basic_done", obs_done, 1);

    // Skip and repeat 2/0/1 x3: 9 busy cycles, never yellow.
    clr_mon();
    run_start(2, 0, 1, 3);
    idle_steps(12);
    chk("skip_busy", obs_busy, 9);
    chk("skip_yellow", obs_yel, 0);
    chk("skip_done", obs_done, 1);

    // Degenerate runs.
    clr_mon();
    run_start(5, 5, 5, 0);
    idle_steps(3);
    run_start(0, 0, 0, 2);
    idle_steps(3);
    chk("degen_busy", obs_busy, 0);
    chk("degen_done", obs_done, 2);

    // Hold 4 cycles mid-yellow: busy stretched by 4.
    clr_mon();
    run_start(3, 2, 4, 1);
    idle_steps(3);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
    idle_steps(10);
    chk("hold_busy", obs_busy, 13);
    chk("hold_done", obs_done, 1);

    // Abort during red with hold also high.
    clr_mon();
    run_start(3, 2, 4, 1);
    idle_steps(6);
    step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
    idle_steps(4);
    chk("abort_pulse", obs_abt, 1);
    chk("abort_nodone", obs_done, 0);

    // Asynchronous reset during green of round 2, then a fresh full run.
    run_start(2, 1, 1, 3);
    idle_steps(5);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_lights", {bus.green, bus.yellow, bus.red, bus.phase}, 5'b100_00);
    chk("async_rst_status", {bus.remaining, bus.busy, bus.done, bus.aborted}, '0);
    m_mode = 0; m_aborted = 1'b0; sched.delete();
    idle_steps(2);
    rst_n = 1'b1;
    clr_mon();
    run_start(2, 1, 1, 2);
    idle_steps(10);
    chk("post_rst_busy", obs_busy, 8);
    chk("post_rst_done", obs_done, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int g, y, r;
      g = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
      y = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
      r = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
      step($urandom_range(0, 3) == 0, g, y, r, $urandom_range(0, 3),
           $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
    end
    idle_steps(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
